viterbi_frame_ctrl: RTL
=======================

// Module: viterbi_frame_ctrl
// PURPOSE
//  Frame sequencer for the rate-1/2 Viterbi decoder. Accepts FRAME_LEN received
//  symbol pairs, fires one ACS step per accepted pair (branch metrics computed
//  downstream of the pair), writes survivors, then runs traceback and collects the
//  decoded bits into a frame buffer. Sits between the rx symbol source and the
//  ACS/survivor-memory/traceback units.
// PARAMETERS
//  FRAME_LEN  16               symbols per frame; legal range 2..256
//  AW         $clog2(FRAME_LEN) localparam, survivor memory address width
// PORTS
//  clk          in   1          single clock, all state on rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  start        in   1          1-cycle pulse, begins a frame; ignored unless IDLE
//  flush        in   1          sync abort; any state -> IDLE next cycle
//  rx_valid     in   1          rx_pair presented this cycle
//  rx_pair      in   2          received symbol pair, forwarded as acs_pair
//  rx_ready     out  1          controller accepts a pair this cycle
//  acs_en       out  1          ACS step enable (one per accepted pair)
//  acs_init     out  1          first ACS step of frame: seed path metrics
//  acs_pair     out  2          pair for the ACS step, valid with acs_en
//  mem_wr_en    out  1          survivor write strobe
//  mem_rd_en    out  1          survivor read strobe (traceback)
//  mem_addr     out  AW         survivor address (write or read)
//  tb_load      out  1          first traceback step: load best end state
//  dec_bit_in   in   1          traceback decoded bit, 1 cycle after mem_rd_en
//  busy         out  1          state != IDLE
//  frame_valid  out  1          1-cycle pulse, frame_out updated
//  frame_out    out  FRAME_LEN  decoded frame, bit i = symbol i; held until next
// BEHAVIOUR
//  Reset: state=IDLE, counters 0, frame_buf 0, frame_out 0, all strobes 0.
//  States: IDLE -> ACS (start) -> TB (last pair accepted) -> CAP -> DONE -> IDLE.
//  IDLE: rx_ready=0; start=1 -> ACS, sym_cnt=0.
//  ACS: rx_ready=1; accept = rx_valid & rx_ready. On accept, same cycle (Mealy):
//   acs_en=1, acs_pair=rx_pair, mem_wr_en=1, mem_addr=sym_cnt,
//   acs_init=(sym_cnt==0); sym_cnt++ next edge. rx_valid=0: no strobes, hold.
//   Accept with sym_cnt==FRAME_LEN-1 -> TB, tb_cnt=FRAME_LEN-1.
//  TB: rx_ready=0; mem_rd_en=1, mem_addr=tb_cnt every cycle; tb_load=1 on
//   first TB cycle only; tb_cnt-- ; after tb_cnt==0 issued -> CAP.
//  Capture: rd_d (mem_rd_en delayed 1) with addr_d: frame_buf[addr_d]<=dec_bit_in.
//   CAP is the one cycle capturing address 0.
//  DONE: frame_out<=frame_buf, frame_valid=1 for this cycle, -> IDLE.
//  Latency: last accepted pair to frame_valid = FRAME_LEN+2 cycles.
//  mem_wr_en and mem_rd_en never high together; acs_en only in ACS.
//  flush has priority over start/accept: strobes forced 0 that cycle, -> IDLE,
//   counters cleared, frame_out/frame_valid untouched (no partial frame).
//  start during busy ignored. Async reset mid-frame: all state/outputs to reset
//   values immediately; frame_out cleared.
//  Counters sized AW; no wrap beyond FRAME_LEN-1 (state change precedes wrap).
// TESTING (FRAME_LEN=8)
//  1 Reset then start, 8 back-to-back pairs -> acs_en 8 cycles, acs_init only
//    on 1st, mem_addr 0..7, then mem_rd_en addr 7..0, frame_valid 10 cycles after
//    last accept.
//  2 rx_valid gaps (pairs 3,6 delayed 2 cycles) -> no strobes in gaps, addr
//    sequence still 0..7, same frame result as test 1.
//  3 Traceback model returns bit=addr[0] -> frame_out=8'b10101010, held after.
//  4 flush in TB at tb_cnt=4 -> IDLE next cycle, no frame_valid, frame_out keeps
//    prior value; next start runs full frame cleanly.
//  5 start pulses during ACS/TB -> ignored, single frame_valid per frame.
//  6 rst_n low mid-ACS (sym_cnt=5) -> busy=0, frame_out=0 without clock edge.

Source files
------------

// File: rtl/viterbi_frame_ctrl_if.sv
// Signal bundle between the Viterbi frame sequencer and its rx source,
// ACS unit, survivor memory, traceback unit and frame consumer.
interface viterbi_frame_ctrl_if #(
  parameter int FRAME_LEN = 16
);
  localparam int AW = $clog2(FRAME_LEN);

  logic                 start;
  logic                 flush;
  logic                 rx_valid;
  logic [1:0]           rx_pair;
  logic                 rx_ready;
  logic                 acs_en;
  logic                 acs_init;
  logic [1:0]           acs_pair;
  logic                 mem_wr_en;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_addr;
  logic                 tb_load;
  logic                 dec_bit_in;
  logic                 busy;
  logic                 frame_valid;
  logic [FRAME_LEN-1:0] frame_out;

  modport master (
    input  start, flush, rx_valid, rx_pair, dec_bit_in,
    output rx_ready, acs_en, acs_init, acs_pair, mem_wr_en, mem_rd_en,
           mem_addr, tb_load, busy, frame_valid, frame_out
  );

  modport slave (
    output start, flush, rx_valid, rx_pair, dec_bit_in,
    input  rx_ready, acs_en, acs_init, acs_pair, mem_wr_en, mem_rd_en,
           mem_addr, tb_load, busy, frame_valid, frame_out
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the rate-1/2 Viterbi decoder: accepts FRAME_LEN symbol
// pairs, drives ACS/survivor writes, then traceback reads and frame capture.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  viterbi_frame_ctrl_if.master bus
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACS,
    TB,
    CAP,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        sym_cnt;
  logic [AW-1:0]        tb_cnt;
  logic [AW-1:0]        addr_d;
  logic                 rd_d;
  logic [FRAME_LEN-1:0] frame_buf;
  logic                 accept;

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // flush wins over everything: all strobes low and straight back to IDLE
  always_comb begin
    state_nxt       = state;
    accept          = 1'b0;
    bus.rx_ready    = 1'b0;
    bus.acs_en      = 1'b0;
    bus.acs_init    = 1'b0;
    bus.acs_pair    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.tb_load     = 1'b0;
    bus.frame_valid = 1'b0;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) state_nxt = ACS;
        ACS: begin
          bus.rx_ready = 1'b1;
          accept       = bus.rx_valid;
          if (accept) begin
            bus.acs_en    = 1'b1;
            bus.acs_init  = (sym_cnt == '0);
            bus.acs_pair  = bus.rx_pair;
            bus.mem_wr_en = 1'b1;
            bus.mem_addr  = sym_cnt;
            if (sym_cnt == LAST) state_nxt = TB;
          end
        end
        TB: begin
          bus.mem_rd_en = 1'b1;
          bus.mem_addr  = tb_cnt;
          bus.tb_load   = (tb_cnt == LAST);
          if (tb_cnt == '0) state_nxt = CAP;
        end
        CAP:  state_nxt = DONE;
        DONE: begin
          bus.frame_valid = 1'b1;
          state_nxt       = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counters change state before they would wrap past FRAME_LEN-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt <= '0;
      tb_cnt  <= '0;
    end else if (bus.flush) begin
      sym_cnt <= '0;
      tb_cnt  <= '0;
    end else begin
      case (state)
        IDLE: sym_cnt <= '0;
        ACS: begin
          if (accept) begin
            if (sym_cnt == LAST) begin
              sym_cnt <= '0;
              tb_cnt  <= LAST;
            end else begin
              sym_cnt <= sym_cnt + AW'(1);
            end
          end
        end
        TB: if (tb_cnt != '0) tb_cnt <= tb_cnt - AW'(1);
        default: ;
      endcase
    end
  end

  // Decoded bit arrives one cycle after its read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d          <= 1'b0;
      addr_d        <= '0;
      frame_buf     <= '0;
      bus.frame_out <= '0;
    end else begin
      rd_d   <= bus.mem_rd_en;
      addr_d <= bus.mem_addr;
      if (rd_d) frame_buf[addr_d] <= bus.dec_bit_in;
      if (state == DONE && !bus.flush) bus.frame_out <= frame_buf;
    end
  end
endmodule
